inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 133 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a DEPTH-entry queue toward decode.
// Optional decode-starvation counter enabled by defining IFQ_PERF_CNT_EN.
module inst_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  output logic [31:0] stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;

  logic [31:0]     inst_mem [DEPTH];
  logic [63:0]     pc_mem   [DEPTH];

  logic push, pop;

  assign imem_req  = (state_q == REQ);
  assign imem_addr = fetch_pc_q;
  assign id_valid  = (count_q != '0) && !redirect_valid;
  assign id_inst   = inst_mem[head_q];
  assign id_pc     = pc_mem[head_q];

  assign push = (state_q == REQ) && imem_ack && !redirect_valid;
  assign pop  = id_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc & ~64'h3;
    end else begin
      if (push) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // A request only issues while a slot is free, so a push never overflows.
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && (count_q < DEPTH_C)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_d = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= imem_data;
      pc_mem[tail_q]   <= fetch_pc_q;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (id_ready && !id_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4, RESET_PC=0).
// Expected stall_cnt depends on whether IFQ_PERF_CNT_EN is defined.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] D0 = 32'h0000_0013;
  localparam logic [31:0] D1 = 32'h0040_0093;
  localparam logic [31:0] D2 = 32'h0080_0113;
  localparam logic [31:0] D3 = 32'h00C0_0193;
  localparam logic [31:0] D4 = 32'h1234_5678;
  localparam logic [31:0] D5 = 32'hCAFE_0001;
  localparam logic [31:0] D6 = 32'hBAD0_0002;
  localparam logic [31:0] D7 = 32'h7777_0007;
  localparam logic [31:0] DLATE = 32'hDEAD_BEEF;

`ifdef IFQ_PERF_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd10;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  inst_fetch_queue #(.RESET_PC(64'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports any mismatch with both values.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then samples 1ns after the rising edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic ready,
                               input logic redir, input logic [63:0] rpc);
    imem_ack       = ack;
    imem_data      = data;
    id_ready       = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_data = '0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("rst_req", {63'd0, imem_req}, 64'd0);
    checkOutput("rst_valid", {63'd0, id_valid}, 64'd0);
    checkOutput("rst_stall", {32'd0, stall_cnt}, 64'd0);
    checkOutput("rst_addr", imem_addr, 64'h0);

    // Starvation window: decode ready, memory silent.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("stall_10", {32'd0, stall_cnt}, {32'd0, STALL_EXP});
    checkOutput("req_held", {63'd0, imem_req}, 64'd1);
    checkOutput("addr_held", imem_addr, 64'h0);

    // Fill the queue with back-to-back acks while decode is blocked.
    applyStimulus(1'b1, D0, 1'b0, 1'b0, '0);
    checkOutput("fill_addr4", imem_addr, 64'h4);
    checkOutput("latency_valid", {63'd0, id_valid}, 64'd1);
    checkOutput("head_inst0", {32'd0, id_inst}, {32'd0, D0});
    checkOutput("head_pc0", id_pc, 64'h0);
    applyStimulus(1'b1, D1, 1'b0, 1'b0, '0);
    checkOutput("fill_addr8", imem_addr, 64'h8);
    applyStimulus(1'b1, D2, 1'b0, 1'b0, '0);
    checkOutput("fill_addrC", imem_addr, 64'hC);
    applyStimulus(1'b1, D3, 1'b0, 1'b0, '0);
    checkOutput("full_req_off", {63'd0, imem_req}, 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("full_req_stays_off", {63'd0, imem_req}, 64'd0);
    checkOutput("full_head", {32'd0, id_inst}, {32'd0, D0});

    // One pop frees a slot -> exactly one new request at 0x10.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("pop_head_pc", id_pc, 64'h4);
    checkOutput("pop_head_inst", {32'd0, id_inst}, {32'd0, D1});
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("refill_req", {63'd0, imem_req}, 64'd1);
    checkOutput("refill_addr", imem_addr, 64'h10);
    applyStimulus(1'b1, D4, 1'b0, 1'b0, '0);
    checkOutput("refull_req_off", {63'd0, imem_req}, 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("no_overfill", {63'd0, imem_req}, 64'd0);

    // Redirect with an outstanding request: late ack must be dropped.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("pre_redir_addr", imem_addr, 64'h14);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h1003);
    checkOutput("drop_req", {63'd0, imem_req}, 64'd0);
    checkOutput("drop_valid", {63'd0, id_valid}, 64'd0);
    applyStimulus(1'b1, DLATE, 1'b0, 1'b0, '0);
    checkOutput("late_ack_hidden", {63'd0, id_valid}, 64'd0);
    checkOutput("idle_after_drop", {63'd0, imem_req}, 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("redir_req", {63'd0, imem_req}, 64'd1);
    checkOutput("redir_addr", imem_addr, 64'h1000);

    // Redirect coinciding with ack and decode-ready.
    applyStimulus(1'b1, D5, 1'b0, 1'b0, '0);
    checkOutput("tgt_head_inst", {32'd0, id_inst}, {32'd0, D5});
    checkOutput("tgt_head_pc", id_pc, 64'h1000);
    checkOutput("tgt_next_addr", imem_addr, 64'h1004);
    applyStimulus(1'b1, D6, 1'b1, 1'b1, 64'h2000);
    checkOutput("combo_empty", {63'd0, id_valid}, 64'd0);
    checkOutput("combo_idle", {63'd0, imem_req}, 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("combo_req", {63'd0, imem_req}, 64'd1);
    checkOutput("combo_addr", imem_addr, 64'h2000);
    checkOutput("combo_still_empty", {63'd0, id_valid}, 64'd0);

    // Fetch address wraps from the top of the 64-bit space to zero.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, DLATE, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, D7, 1'b0, 1'b0, '0);
    checkOutput("wrap_addr", imem_addr, 64'h0);
    checkOutput("wrap_head_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_head_inst", {32'd0, id_inst}, {32'd0, D7});
    checkOutput("wrap_valid", {63'd0, id_valid}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
